// File: rtl/kernel_launch_if.sv
// kernel_launch_if: host cfg/launch handshake, status and dispatch-unit control bundle
interface kernel_launch_if #(parameter int CYCLE_W = 16);
  logic cfg_write_enable;
  logic [7:0] cfg_thread_count;
  logic launch_valid;
  logic launch_ready;
  logic busy;
  logic kernel_done;
  logic timeout;
  logic empty_launch;
  logic [CYCLE_W-1:0] cycle_count;
  logic dispatch_reset;
  logic dispatch_start;
  logic [7:0] dispatch_thread_count;
  logic dispatch_done;
  modport master(
    output cfg_write_enable, cfg_thread_count, launch_valid, dispatch_done,
    input launch_ready, busy, kernel_done, timeout, empty_launch, cycle_count,
          dispatch_reset, dispatch_start, dispatch_thread_count
  );
  modport slave(
    input cfg_write_enable, cfg_thread_count, launch_valid, dispatch_done,
    output launch_ready, busy, kernel_done, timeout, empty_launch, cycle_count,
           dispatch_reset, dispatch_start, dispatch_thread_count
  );
endinterface

// File: rtl/kernel_launch_ctrl.sv
// kernel_launch_ctrl: latches thread count, sequences dispatch reset/start on launch, reports done/cycles/timeout
module kernel_launch_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int CYCLE_W = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic clk,
  input logic reset,
  kernel_launch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam int RC_W = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  state_t state, state_nx;
  logic [7:0] shadow, thread_count, cap;
  logic [RC_W-1:0] rc;
  logic [CYCLE_W-1:0] cnt, cnt_inc;
  logic timeout_q, empty_q, ready, accept, to_hit;
  assign ready = state == IDLE || state == DONE;
  assign accept = bus.launch_valid && ready;
  assign cap = bus.cfg_write_enable ? bus.cfg_thread_count : shadow;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign to_hit = TIMEOUT_CYCLES != 0 && cnt_inc == CYCLE_W'(TIMEOUT_CYCLES);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (accept) state_nx = cap == '0 ? DONE : CLEAR;
      CLEAR: if (rc == '0) state_nx = RUN;
      RUN: if (bus.dispatch_done || to_hit) state_nx = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shadow <= '0;
      thread_count <= '0;
      rc <= '0;
      cnt <= '0;
      timeout_q <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.cfg_write_enable && ready) shadow <= bus.cfg_thread_count;
      if (accept) begin
        thread_count <= cap;
        rc <= RC_W'(RESET_CYCLES - 1);
        cnt <= '0;
        timeout_q <= 1'b0;
        empty_q <= cap == '0;
      end
      if (state == CLEAR && rc != '0) rc <= rc - 1'b1;
      if (state == RUN) begin
        cnt <= cnt_inc;
        timeout_q <= !bus.dispatch_done && to_hit;
      end
    end
  end
  assign bus.launch_ready = ready;
  assign bus.busy = state == CLEAR || state == RUN;
  assign bus.kernel_done = state == DONE;
  assign bus.dispatch_reset = state != RUN;
  assign bus.dispatch_start = state == RUN;
  assign bus.timeout = timeout_q;
  assign bus.empty_launch = empty_q;
  assign bus.cycle_count = cnt;
  assign bus.dispatch_thread_count = thread_count;
endmodule
